// File: rtl/reg_dump.sv
`default_nettype none
// =============================================================================
// Module   : reg_dump
// Brief    : Streams a register-file range as a byte frame: header, words MSB
//            first, then an XOR checksum of the word bytes.
// Revision : 1.0
// =============================================================================
module reg_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  ra4,
  input  logic [31:0] rd4,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] c_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] c_LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic [31:0] r_shift;
  logic [7:0]  r_csum;
  logic [1:0]  r_bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Outputs decode from state only, so tx_valid never sees tx_ready.
  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[31:24];
        if (tx_ready && (r_bcnt == 2'd3))
          w_next = (r_idx == c_LAST) ? S_CSUM : S_LOAD;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = r_csum;
        if (tx_ready) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= c_FIRST;
      r_shift <= 32'd0;
      r_csum  <= 8'h00;
      r_bcnt  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= c_FIRST;
            r_csum <= 8'h00;
          end
        end
        S_LOAD: begin
          r_shift <= rd4;
          r_bcnt  <= 2'd0;
        end
        S_SEND: begin
          if (tx_ready) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_csum  <= r_csum ^ r_shift[31:24];
            r_bcnt  <= r_bcnt + 2'd1;
            // Index stops at LAST_REG so ra4 keeps showing the final register.
            if ((r_bcnt == 2'd3) && (r_idx != c_LAST))
              r_idx <= r_idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ra4 = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// =============================================================================
// Module   : tb_reg_dump
// Brief    : Self-checking bench for reg_dump against a frame-level model.
// Revision : 1.0
// =============================================================================
module tb_reg_dump;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0] val;
    logic [47:0] exp_frame;
    int          exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic [31:0] snap [32];

  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [4:0]  ra4_a;
  logic [31:0] rd4_a;
  logic [7:0]  data_a;

  logic        start_b, ready_b, valid_b, busy_b, done_b;
  logic [4:0]  ra4_b;
  logic [31:0] rd4_b;
  logic [7:0]  data_b;

  assign rd4_a = (ra4_a == 5'd0) ? 32'd0 : regs[ra4_a];
  assign rd4_b = (ra4_b == 5'd0) ? 32'd0 : regs[ra4_b];

  reg_dump u_dut (
    .clk(clk), .rst(rst), .start(start_a), .ra4(ra4_a), .rd4(rd4_a),
    .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .busy(busy_a), .done(done_a)
  );

  reg_dump #(.FIRST_REG(16), .LAST_REG(16), .HEADER(8'hA5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_b), .ra4(ra4_b), .rd4(rd4_b),
    .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .busy(busy_b), .done(done_b)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  bq_t got;
  int  busy_cyc, done_cnt, done_at, stall_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bq_t model_frame(input int first, input int last);
    bq_t q;
    logic [7:0]  x;
    logic [31:0] v;
    x = 8'h00;
    q.push_back(8'hA5);
    for (int r = first; r <= last; r++) begin
      v = (r == 0) ? 32'd0 : snap[r];
      for (int k = 3; k >= 0; k--) begin
        q.push_back(v[8*k +: 8]);
        x = x ^ v[8*k +: 8];
      end
    end
    q.push_back(x);
    return q;
  endfunction

  task automatic check_frame(input string name, input bq_t exp);
    int bad;
    bad = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (bad >= 0 || got.size() != exp.size()) begin
      n_fail++;
      if (bad >= 0)
        $display("FAIL %s: byte[%0d] got %0h, required %0h (len %0d/%0d)",
                 name, bad, got[bad], exp[bad], got.size(), exp.size());
      else
        $display("FAIL %s: length got %0d, required %0d", name, got.size(), exp.size());
    end
  endtask

  // mode: 0 ready always, 1 toggling, 2 random. Returns early when the
  // abort byte index is being presented.
  task automatic run_frame(input int mode, input bit hold, input int wr_at_reg,
                           input int abort_at, output bit aborted);
    logic       pv, pr;
    logic [7:0] pd;
    bit         seen_done, wrote;
    got.delete();
    busy_cyc = 0; done_cnt = 0; done_at = -1; stall_err = 0;
    aborted = 0; seen_done = 0; wrote = 0;
    pv = 0; pr = 0; pd = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    for (int cyc = 0; cyc < 2000 && !seen_done && !aborted; cyc++) begin
      @(negedge clk);
      if (!hold) start_a = 1'b0;
      if (busy_a) busy_cyc++;
      if (done_a) begin
        done_cnt++;
        done_at   = busy_cyc;
        seen_done = 1;
        start_a   = 1'b0;
      end
      if (pv && !pr && (valid_a !== 1'b1 || data_a !== pd)) stall_err++;
      if (abort_at >= 0 && valid_a && got.size() == abort_at) begin
        aborted = 1;
      end else begin
        if (wr_at_reg >= 0 && !wrote && valid_a && ra4_a == 5'(wr_at_reg)) begin
          regs[31] = 32'hDEADBEEF;
          regs[5]  = 32'h55555555;
          wrote    = 1;
        end
        case (mode)
          0:       ready_a = 1'b1;
          1:       ready_a = ~ready_a;
          default: ready_a = ($urandom_range(0, 3) != 0);
        endcase
        if (valid_a && ready_a) got.push_back(data_a);
        pv = valid_a; pd = data_a; pr = ready_a;
      end
    end
    check("frame_finished", 64'(seen_done | aborted), 64'd1);
  endtask

  task automatic run16(input vec_t v);
    logic [47:0] fr;
    int          nb, bc;
    bit          fin;
    regs[16] = v.val;
    fr = 48'd0; nb = 0; bc = 0; fin = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (busy_b) bc++;
      if (valid_b) begin
        fr = {fr[39:0], data_b};
        nb++;
      end
      if (done_b) fin = 1;
    end
    check("r16_frame", {fr, 16'(nb)}, {v.exp_frame, 16'd6});
    check("r16_busy", 64'(bc), 64'(v.exp_busy));
  endtask

  bit   ab;
  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h12345678, 48'hA5_12345678_08, 8};
    vecs[1] = '{32'hFFFFFFFF, 48'hA5_FFFFFFFF_00, 8};
    vecs[2] = '{32'h000000AA, 48'hA5_000000AA_AA, 8};
    vecs[3] = '{32'h01020408, 48'hA5_01020408_0F, 8};
    vecs[4] = '{32'hDEADBEEF, 48'hA5_DEADBEEF_22, 8};

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[29] = 32'h3C;
    start_a = 0; ready_a = 1; start_b = 0; ready_b = 1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_data",  64'(data_a),  64'd0);
    check("rst_ra4",   64'(ra4_a),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Power-up frame, ready tied high
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    run_frame(0, 0, -1, -1, ab);
    check_frame("pwrup_frame", model_frame(0, 31));
    check("pwrup_busy", 64'(busy_cyc), 64'd163);
    check("pwrup_done_at", 64'(done_at), 64'd163);
    check("pwrup_done_cnt", 64'(done_cnt), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done_a), 64'd0);
    check("idle_ra4_last", 64'(ra4_a), 64'd31);

    // Ready toggling every cycle
    run_frame(1, 0, -1, -1, ab);
    check_frame("toggle_frame", model_frame(0, 31));
    check("toggle_stall", 64'(stall_err), 64'd0);

    // Start held through the whole dump
    run_frame(0, 1, -1, -1, ab);
    check_frame("hold_frame", model_frame(0, 31));
    check("hold_done_cnt", 64'(done_cnt), 64'd1);
    @(negedge clk);
    check("hold_no_restart", 64'(busy_a), 64'd0);

    // Writes during dump: reg31 not yet loaded, reg5 already loaded
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    snap[31] = 32'hDEADBEEF;
    run_frame(0, 0, 10, -1, ab);
    check_frame("middump_write", model_frame(0, 31));

    // Async reset during 3rd byte of reg 5
    run_frame(0, 0, -1, 23, ab);
    check("abort_reached", 64'(ab), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 64'(valid_a), 64'd0);
    check("abort_busy",  64'(busy_a),  64'd0);
    check("abort_data",  64'(data_a),  64'd0);
    check("abort_ra4",   64'(ra4_a),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    run_frame(0, 0, -1, -1, ab);
    check_frame("after_abort_frame", model_frame(0, 31));

    // Randomised contents with random back-pressure
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 32; i++) snap[i] = regs[i];
      run_frame(2, 0, -1, -1, ab);
      check_frame("rand_frame", model_frame(0, 31));
      check("rand_stall", 64'(stall_err), 64'd0);
    end

    // Single-register instance, table-driven
    for (int i = 0; i < 5; i++) run16(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have parameter HEADER, default 8'hA5, frame start byte.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  dump request, sampled on rising clk.
REQ-007 SHALL have port ra4  out  5  register file diagnostic read address.
REQ-008 SHALL have port rd4  in  32  register file diagnostic read data, combinational from ra4; index 0 reads 0.
REQ-009 SHALL have port tx_data  out  8  byte stream data.
REQ-010 SHALL have port tx_valid  out  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_ready  in  1  downstream accepts byte.
REQ-012 SHALL have port busy  out  1  dump in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, LOAD, SEND, CSUM, DONE; busy = 1 in every state except IDLE.
REQ-015 IDLE: start=1 -> HDR, index register (drives ra4) set to FIRST_REG, checksum cleared to 0; start=0 -> stay.
REQ-016 start SHALL be ignored in any state other than IDLE (no restart, no queuing).
REQ-017 HDR: tx_valid=1, tx_data=HEADER; on tx_valid&&tx_ready at rising edge -> LOAD.
REQ-018 LOAD: one cycle, tx_valid=0; capture rd4 into 32-bit shift register, byte counter cleared -> SEND.
REQ-019 SEND: tx_valid=1, tx_data=shift[31:24] (MSB first); on handshake shift left 8, checksum ^= byte, byte counter +1.
REQ-020 SEND after 4th handshake: if index == LAST_REG -> CSUM; else index +1 -> LOAD.
REQ-021 CSUM: tx_valid=1, tx_data = XOR of all register bytes sent (header excluded); on handshake -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, tx_valid=0 -> IDLE.
REQ-023 Transfer occurs only when tx_valid and tx_ready are both 1 at a rising edge; while tx_valid=1 and no transfer, tx_data SHALL stay stable and tx_valid SHALL stay 1.
REQ-024 tx_valid SHALL not depend combinationally on tx_ready.
REQ-025 Frame length SHALL be 2 + 4*(LAST_REG-FIRST_REG+1) bytes; default 130.
REQ-026 With tx_ready tied 1, busy SHALL be high for exactly 3 + 5*(LAST_REG-FIRST_REG+1) cycles (default 163).
REQ-027 Each word SHALL reflect register contents at its LOAD cycle; register writes during the dump affect only registers not yet loaded.
REQ-028 ra4 SHALL hold the current index in all states; in IDLE it holds the last index used (FIRST_REG after reset).
REQ-029 Index SHALL never exceed LAST_REG; no wrap-around past 31.

Reset
REQ-030 rst=1 SHALL immediately (without clock) force IDLE, tx_valid=0, busy=0, done=0, tx_data=0, ra4=FIRST_REG, checksum=0, byte counter=0.
REQ-031 rst asserted mid-dump SHALL abort the frame with no done pulse; the next start begins a fresh frame from HEADER.

Verification
REQ-032 Regfile at power-up (all 0, reg29=0x3C), tx_ready=1, start pulse -> A5, 116 zero bytes, 00 00 00 3C, 8 zero bytes, checksum 3C; done 163 cycles after busy rises.
REQ-033 Same frame with tx_ready toggling 1/0 every cycle -> identical byte sequence, tx_data stable during every stall, no byte duplicated or dropped.
REQ-034 FIRST_REG=LAST_REG=16, reg16=0x12345678 -> A5 12 34 56 78, checksum 0x08; busy 8 cycles.
REQ-035 rst pulsed during 3rd byte of reg 5 -> tx_valid=0, busy=0 at once, no done; new start -> full frame from A5.
REQ-036 start held high throughout dump -> single frame; second frame begins from IDLE re-entry only.
REQ-037 Write reg31=0xDEADBEEF while reg 10 is being sent -> reg31 bytes DE AD BE EF in frame; checksum includes them.
